irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 41 ++++
 rtl/irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_irq_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Control-op encoding plus the bundle of CPU/sequencer signals around the interrupt controller.
// slave = controller view, master = CPU core / sequencer view.
package irq_ctrl_pkg;
  typedef enum logic [2:0] {
    CTL_NONE = 3'd0,
    CTL_EI   = 3'd1,
    CTL_DI   = 3'd2,
    CTL_RETI = 3'd3,
    CTL_HALT = 3'd4
  } ctl_op_t;
endpackage

interface irq_ctrl_if;
  import irq_ctrl_pkg::*;

  logic        instr_done;
  ctl_op_t     ctl_op;
  logic [4:0]  irq_req;
  logic        if_wr_en;
  logic [4:0]  if_wr_data;
  logic        ie_wr_en;
  logic [7:0]  ie_wr_data;
  logic [7:0]  if_rd_data;
  logic [7:0]  ie_rd_data;
  logic        irq_take;
  logic        irq_ack;
  logic [15:0] irq_vector;
  logic        halt_wake;
  logic        halted;
  logic        ime;

  modport slave (
    input  instr_done, ctl_op, irq_req, if_wr_en, if_wr_data, ie_wr_en, ie_wr_data, irq_ack,
    output if_rd_data, ie_rd_data, irq_take, irq_vector, halt_wake, halted, ime
  );

  modport master (
    output instr_done, ctl_op, irq_req, if_wr_en, if_wr_data, ie_wr_en, ie_wr_data, irq_ack,
    input  if_rd_data, ie_rd_data, irq_take, irq_vector, halt_wake, halted, ime
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: IF/IE registers, three-state IME, HALT handling and vector dispatch.
// Dispatch raises irq_take one cycle after a boundary and holds it until irq_ack.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IME_OFF, IME_PEND, IME_ON} ime_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HALTED, ST_DISPATCH} st_t;

  logic [4:0]  if_q;
  logic [7:0]  ie_q;
  ime_t        ime_q;
  ime_t        ime_nxt;
  st_t         st_q;
  logic        irq_take_q;
  logic        halt_wake_q;
  logic        halted_q;
  logic [15:0] vec_cap_q;

  logic [4:0]  pend;
  logic        pend_any;
  logic [2:0]  pend_idx;
  logic [4:0]  ack_mask;
  logic [15:0] vec_live;
  logic        ack_vld;
  logic        ime_eff;
  logic [4:0]  if_nxt;

  assign pend     = ie_q[4:0] & if_q;
  assign pend_any = |pend;
  assign ack_vld  = bus.irq_ack && (st_q == ST_DISPATCH);

  assign ime_eff = (ime_q == IME_ON) ||
                   ((ime_q == IME_PEND) && bus.instr_done &&
                    (bus.ctl_op != CTL_DI) && (bus.ctl_op != CTL_EI));

  // Scan downward so the lowest set bit (highest priority) wins.
  always_comb begin
    pend_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) pend_idx = 3'(i);
    end
  end

  assign ack_mask = pend_any ? (5'd1 << pend_idx) : 5'd0;
  assign vec_live = pend_any ? (16'h0040 + {10'd0, pend_idx, 3'd0}) : 16'h0000;

  // Hardware requests are ORed last so a simultaneous CPU write or ack never drops them.
  always_comb begin
    if_nxt = if_q;
    if (ack_vld)      if_nxt = if_nxt & ~ack_mask;
    if (bus.if_wr_en) if_nxt = bus.if_wr_data;
    if_nxt = if_nxt | bus.irq_req;
  end

  always_comb begin
    ime_nxt = ime_q;
    if (bus.instr_done) begin
      case (bus.ctl_op)
        CTL_EI:   if (ime_q == IME_OFF) ime_nxt = IME_PEND;
        CTL_DI:   ime_nxt = IME_OFF;
        CTL_RETI: ime_nxt = IME_ON;
        default:  if (ime_q == IME_PEND) ime_nxt = IME_ON;
      endcase
    end
    if (ack_vld) ime_nxt = IME_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q  <= 5'd0;
      ie_q  <= 8'd0;
      ime_q <= IME_OFF;
    end else begin
      if_q  <= if_nxt;
      ime_q <= ime_nxt;
      if (bus.ie_wr_en) ie_q <= bus.ie_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      irq_take_q  <= 1'b0;
      halt_wake_q <= 1'b0;
      halted_q    <= 1'b0;
      vec_cap_q   <= 16'h0000;
    end else begin
      halt_wake_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (bus.instr_done) begin
            if (bus.ctl_op == CTL_HALT) begin
              if (!pend_any) begin
                st_q     <= ST_HALTED;
                halted_q <= 1'b1;
              end else begin
                halt_wake_q <= 1'b1;
                if (ime_eff) begin
                  st_q       <= ST_DISPATCH;
                  irq_take_q <= 1'b1;
                end
              end
            end else if (ime_eff && pend_any) begin
              st_q       <= ST_DISPATCH;
              irq_take_q <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          // Wake is independent of IME; only the follow-on dispatch needs it.
          if (pend_any) begin
            halt_wake_q <= 1'b1;
            halted_q    <= 1'b0;
            if (ime_q == IME_ON) begin
              st_q       <= ST_DISPATCH;
              irq_take_q <= 1'b1;
            end else begin
              st_q <= ST_IDLE;
            end
          end
        end
        ST_DISPATCH: begin
          if (ack_vld) begin
            st_q       <= ST_IDLE;
            irq_take_q <= 1'b0;
            vec_cap_q  <= vec_live;
          end
        end
        default: begin
          st_q       <= ST_IDLE;
          irq_take_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_rd_data = {3'b111, if_q};
  assign bus.ie_rd_data = ie_q;
  assign bus.irq_take   = irq_take_q;
  assign bus.irq_vector = (st_q == ST_DISPATCH) ? vec_live : vec_cap_q;
  assign bus.halt_wake  = halt_wake_q;
  assign bus.halted     = halted_q;
  assign bus.ime        = (ime_q == IME_ON);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: dispatch, priority, HALT wake, EI/DI, mid-dispatch IE clear, reset.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  irq_ctrl_if bus();

  irq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic boundary(input ctl_op_t op);
    bus.instr_done = 1'b1;
    bus.ctl_op     = op;
    step();
    bus.instr_done = 1'b0;
    bus.ctl_op     = CTL_NONE;
  endtask

  task automatic wr_ie(input logic [7:0] d);
    bus.ie_wr_en   = 1'b1;
    bus.ie_wr_data = d;
    step();
    bus.ie_wr_en   = 1'b0;
  endtask

  task automatic wr_if(input logic [4:0] d);
    bus.if_wr_en   = 1'b1;
    bus.if_wr_data = d;
    step();
    bus.if_wr_en   = 1'b0;
  endtask

  task automatic req(input logic [4:0] d);
    bus.irq_req = d;
    step();
    bus.irq_req = 5'd0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n          = 1'b0;
    bus.instr_done = 1'b0;
    bus.ctl_op     = CTL_NONE;
    bus.irq_req    = 5'd0;
    bus.if_wr_en   = 1'b0;
    bus.if_wr_data = 5'd0;
    bus.ie_wr_en   = 1'b0;
    bus.ie_wr_data = 8'd0;
    bus.irq_ack    = 1'b0;

    #1;
    chk("rst_if_rd", 16'(bus.if_rd_data), 16'h00E0);
    chk("rst_ie_rd", 16'(bus.ie_rd_data), 16'h0000);
    chk("rst_take",  16'(bus.irq_take),   16'h0000);
    chk("rst_vec",   bus.irq_vector,      16'h0000);
    chk("rst_halted",16'(bus.halted),     16'h0000);
    chk("rst_ime",   16'(bus.ime),        16'h0000);
    step();
    step();
    rst_n = 1'b1;
    step();

    // EI, request, NOP boundary -> VBLANK dispatch
    wr_ie(8'h01);
    chk("ie_rd_01", 16'(bus.ie_rd_data), 16'h0001);
    boundary(CTL_EI);
    chk("ei_no_take", 16'(bus.irq_take), 16'h0000);
    req(5'h01);
    chk("if_vblank", 16'(bus.if_rd_data), 16'h00E1);
    boundary(CTL_NONE);
    chk("s1_take",  16'(bus.irq_take), 16'h0001);
    chk("s1_vec",   bus.irq_vector,    16'h0040);
    chk("s1_ime_on",16'(bus.ime),      16'h0001);
    ack();
    chk("s1_if_clr", 16'(bus.if_rd_data), 16'h00E0);
    chk("s1_ime_off",16'(bus.ime),        16'h0000);
    chk("s1_take_lo",16'(bus.irq_take),   16'h0000);
    chk("s1_vec_cap",bus.irq_vector,      16'h0040);

    // Priority: bit2 before bit4
    bus.ie_wr_en = 1'b1; bus.ie_wr_data = 8'h1F;
    bus.if_wr_en = 1'b1; bus.if_wr_data = 5'h14;
    step();
    bus.ie_wr_en = 1'b0; bus.if_wr_en = 1'b0;
    boundary(CTL_EI);
    boundary(CTL_NONE);
    chk("s2_take", 16'(bus.irq_take), 16'h0001);
    chk("s2_vec",  bus.irq_vector,    16'h0050);
    ack();
    chk("s2_if_10", 16'(bus.if_rd_data), 16'h00F0);
    boundary(CTL_RETI);
    chk("s2_reti_no_take", 16'(bus.irq_take), 16'h0001 ^ 16'h0001);
    chk("s2_reti_ime", 16'(bus.ime), 16'h0001);
    boundary(CTL_NONE);
    chk("s2_vec2", bus.irq_vector, 16'h0060);
    ack();
    chk("s2_if_0", 16'(bus.if_rd_data), 16'h00E0);

    // HALT with IME off, woken by TIMER-class request
    wr_ie(8'h04);
    boundary(CTL_HALT);
    chk("s3_halted", 16'(bus.halted), 16'h0001);
    req(5'h04);
    chk("s3_still_halted", 16'(bus.halted), 16'h0001);
    step();
    chk("s3_wake",   16'(bus.halt_wake), 16'h0001);
    chk("s3_unhalt", 16'(bus.halted),    16'h0000);
    chk("s3_no_take",16'(bus.irq_take),  16'h0000);
    chk("s3_if_04",  16'(bus.if_rd_data),16'h00E4);
    step();
    chk("s3_wake_pulse", 16'(bus.halt_wake), 16'h0000);
    boundary(CTL_HALT);
    chk("s3b_no_halt", 16'(bus.halted),    16'h0000);
    chk("s3b_wake",    16'(bus.halt_wake), 16'h0001);
    chk("s3b_no_take", 16'(bus.irq_take),  16'h0000);

    // EI immediately followed by DI never dispatches
    boundary(CTL_EI);
    chk("s4_ei_take", 16'(bus.irq_take), 16'h0000);
    boundary(CTL_DI);
    chk("s4_di_take", 16'(bus.irq_take), 16'h0000);
    chk("s4_ime",     16'(bus.ime),      16'h0000);
    boundary(CTL_NONE);
    chk("s4_nop_take",16'(bus.irq_take), 16'h0000);
    ack();
    chk("s4_stray_ack_if", 16'(bus.if_rd_data), 16'h00E4);
    wr_if(5'h00);

    // IE cleared mid-dispatch -> null vector, IF kept
    bus.ie_wr_en = 1'b1; bus.ie_wr_data = 8'h02;
    bus.if_wr_en = 1'b1; bus.if_wr_data = 5'h02;
    step();
    bus.ie_wr_en = 1'b0; bus.if_wr_en = 1'b0;
    boundary(CTL_RETI);
    boundary(CTL_NONE);
    chk("s5_vec48", bus.irq_vector, 16'h0048);
    wr_ie(8'h00);
    chk("s5_vec_live0", bus.irq_vector,  16'h0000);
    chk("s5_take_held", 16'(bus.irq_take), 16'h0001);
    ack();
    chk("s5_vec0",  bus.irq_vector,       16'h0000);
    chk("s5_if_kept",16'(bus.if_rd_data), 16'h00E2);
    chk("s5_ime",   16'(bus.ime),         16'h0000);

    // Hardware request beats a same-cycle CPU write
    bus.if_wr_en = 1'b1; bus.if_wr_data = 5'h00; bus.irq_req = 5'h08;
    step();
    bus.if_wr_en = 1'b0; bus.irq_req = 5'h00;
    chk("s6_if_08", 16'(bus.if_rd_data), 16'h00E8);

    // Reset mid-dispatch
    wr_ie(8'h08);
    boundary(CTL_RETI);
    boundary(CTL_NONE);
    chk("s6_vec58", bus.irq_vector, 16'h0058);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6r_take",  16'(bus.irq_take),   16'h0000);
    chk("s6r_vec",   bus.irq_vector,      16'h0000);
    chk("s6r_if",    16'(bus.if_rd_data), 16'h00E0);
    chk("s6r_ie",    16'(bus.ie_rd_data), 16'h0000);
    chk("s6r_ime",   16'(bus.ime),        16'h0000);
    chk("s6r_halted",16'(bus.halted),     16'h0000);
    chk("s6r_wake",  16'(bus.halt_wake),  16'h0000);
    step();
    rst_n = 1'b1;
    step();
    chk("s6r_post_take", 16'(bus.irq_take), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
